// File: rtl/hdmi_line_prefetch_ctrl.sv
// hdmi_line_prefetch_ctrl
//   Prefetches the next visible line from the framebuffer into one bank of a
//   ping-pong line buffer during horizontal blanking. At the same time it
//   streams the current line out of the other bank, in step with pixel_x/pixel_y.
//
// Ports
//   clk, rst              pixel clock, synchronous active-high reset
//   pixel_x/pixel_y       raster position from the timing generator
//   hsync/vsync/active    timing generator sync and visible-region flags
//   rd_req_valid/_addr    burst read request (BURST_LEN words from _addr)
//   rd_req_ready          memory accepted the request
//   rd_data_valid/rd_data in-order returned words
//   pixel_data/valid      pixel stream to the encoder (1-cycle latency)
//   hsync_o/vsync_o       syncs delayed to line up with pixel_data
//   busy                  a line fetch is in progress
//   underflow(_count)     a fetch trigger arrived while busy (saturating count)
module hdmi_line_prefetch_ctrl #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_TOTAL   = 628,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              active,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_ready,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              busy,
    output logic              underflow,
    output logic [7:0]        underflow_count
);

    localparam int unsigned NREQ = H_ACTIVE / BURST_LEN;
    localparam int unsigned PW   = $clog2(H_ACTIVE + 1);
    localparam int unsigned CW   = $clog2(NREQ + 1);

    localparam logic [9:0]        X_TRIG     = 10'(H_ACTIVE);
    localparam logic [9:0]        Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]        Y_VIS_LAST = 10'(V_ACTIVE - 1);
    localparam logic [PW-1:0]     PTR_END    = PW'(H_ACTIVE - 1);
    localparam logic [CW-1:0]     CNT_END    = CW'(NREQ - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state;
    logic [CW-1:0]       req_cnt;
    logic [PW-1:0]       wptr;
    logic [ADDR_W-1:0]   base;
    logic                tgt_bank;

    logic [DATA_W-1:0]   mem [0:1][0:H_ACTIVE-1];

    logic                first_line;
    logic                trig;
    logic [ADDR_W-1:0]   next_base;
    logic                wr_en;

    // Trigger at the end of the visible part of a line. The last frame line
    // fetches line 0; the lines from V_ACTIVE-1 to V_TOTAL-2 fetch nothing.
    always_comb begin
        first_line = (pixel_y == Y_LAST);
        trig       = (pixel_x == X_TRIG) && (first_line || (pixel_y < Y_VIS_LAST));
        next_base  = first_line ? '0 : base + LINE_STEP;
        wr_en      = busy && rd_data_valid && !rst;
    end

    // Burst addresses are stepped by BURST_LEN on each accepted request,
    // which equals base + req_cnt*BURST_LEN without a multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            req_cnt         <= '0;
            wptr            <= '0;
            base            <= '0;
            tgt_bank        <= 1'b0;
            rd_req_valid    <= 1'b0;
            rd_req_addr     <= '0;
            busy            <= 1'b0;
            underflow       <= 1'b0;
            underflow_count <= '0;
        end else begin
            underflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        base         <= next_base;
                        rd_req_addr  <= next_base;
                        rd_req_valid <= 1'b1;
                        req_cnt      <= '0;
                        wptr         <= '0;
                        tgt_bank     <= first_line ? 1'b0 : ~pixel_y[0];
                        busy         <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ, WAIT: begin
                    // The fetch in flight is left untouched by a late trigger.
                    if (trig) begin
                        underflow <= 1'b1;
                        if (underflow_count != '1)
                            underflow_count <= underflow_count + 8'd1;
                    end
                    if (state == REQ && rd_req_ready) begin
                        req_cnt     <= req_cnt + CW'(1);
                        rd_req_addr <= rd_req_addr + BURST_STEP;
                        if (req_cnt == CNT_END) begin
                            rd_req_valid <= 1'b0;
                            state        <= WAIT;
                        end
                    end
                    // Line complete: takes priority over the REQ->WAIT move.
                    if (rd_data_valid) begin
                        wptr <= wptr + PW'(1);
                        if (wptr == PTR_END) begin
                            rd_req_valid <= 1'b0;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: begin
                    rd_req_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Line buffer storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[tgt_bank][wptr] <= rd_data;
    end

    // Display path. A same-bank write in the same cycle yields the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            hsync_o     <= 1'b0;
            vsync_o     <= 1'b0;
        end else begin
            pixel_data  <= active ? mem[pixel_y[0]][pixel_x] : '0;
            pixel_valid <= active;
            hsync_o     <= hsync;
            vsync_o     <= vsync;
        end
    end

endmodule

// File: tb/tb_hdmi_line_prefetch_ctrl.sv
// Self-checking bench for hdmi_line_prefetch_ctrl: directed scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_hdmi_line_prefetch_ctrl;

    localparam int H     = 800;
    localparam int VA    = 600;
    localparam int VT    = 628;
    localparam int BL    = 16;
    localparam int NREQ  = H / BL;
    localparam int AMASK = (1 << 19) - 1;

    logic        clk;
    logic        rst;
    logic [9:0]  pixel_x, pixel_y;
    logic        hsync, vsync, active;
    logic        rd_req_valid;
    logic [18:0] rd_req_addr;
    logic        rd_req_ready;
    logic        rd_data_valid;
    logic [11:0] rd_data;
    logic [11:0] pixel_data;
    logic        pixel_valid, hsync_o, vsync_o, busy, underflow;
    logic [7:0]  underflow_count;

    hdmi_line_prefetch_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(VA), .V_TOTAL(VT),
        .BURST_LEN(BL), .DATA_W(12), .ADDR_W(19)
    ) dut (
        .clk(clk), .rst(rst),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .hsync(hsync), .vsync(vsync), .active(active),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .rd_req_ready(rd_req_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .hsync_o(hsync_o), .vsync_o(vsync_o),
        .busy(busy), .underflow(underflow), .underflow_count(underflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_fetch;
    int          m_base, m_reqs, m_words, m_tgt, m_ucnt;
    bit          e_under, e_pv, e_hs, e_vs, e_pdk;
    int          e_pd;
    logic [11:0] mb [2][H];
    bit          kn [2][H];

    always @(posedge clk) begin : model
        bit trig;
        int line;
        if (rst) begin
            e_pv = 0; e_hs = 0; e_vs = 0; e_pd = 0; e_pdk = 1;
        end else begin
            e_pv = active; e_hs = hsync; e_vs = vsync;
            if (active) begin
                e_pd  = int'(mb[pixel_y[0]][pixel_x]);
                e_pdk = kn[pixel_y[0]][pixel_x];
            end else begin
                e_pd = 0; e_pdk = 1;
            end
        end
        if (rst) begin
            if (m_fetch) for (int i = 0; i < H; i++) kn[m_tgt][i] = 0;
            m_fetch = 0; m_base = 0; m_ucnt = 0; e_under = 0;
            m_reqs = 0; m_words = 0;
        end else begin
            trig = (int'(pixel_x) == H) &&
                   (int'(pixel_y) == VT - 1 || int'(pixel_y) < VA - 1);
            e_under = trig && m_fetch;
            if (e_under && m_ucnt < 255) m_ucnt++;
            if (m_fetch) begin
                if (m_reqs < NREQ && rd_req_ready) m_reqs++;
                if (rd_data_valid) begin
                    mb[m_tgt][m_words] = rd_data;
                    kn[m_tgt][m_words] = 1;
                    m_words++;
                    if (m_words == H) m_fetch = 0;
                end
            end else if (trig) begin
                line    = (int'(pixel_y) == VT - 1) ? 0 : int'(pixel_y) + 1;
                m_base  = (line == 0) ? 0 : ((m_base + H) & AMASK);
                m_tgt   = line % 2;
                m_fetch = 1; m_reqs = 0; m_words = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, int'(m_fetch));
            chk("rd_req_valid", rd_req_valid, int'(m_fetch && m_reqs < NREQ));
            if (m_fetch && m_reqs < NREQ)
                chk("rd_req_addr", rd_req_addr, (m_base + m_reqs * BL) & AMASK);
            chk("underflow", underflow, int'(e_under));
            chk("underflow_count", underflow_count, m_ucnt);
            chk("pixel_valid", pixel_valid, int'(e_pv));
            chk("hsync_o", hsync_o, int'(e_hs));
            chk("vsync_o", vsync_o, int'(e_vs));
            if (e_pdk) chk("pixel_data", pixel_data, e_pd);
        end
    end

    // ---------------- stimulus helpers ----------------
    int rdy_pct = 100, val_pct = 100, stale_pct = 0;
    bit pattern = 1;
    int dut_hs = 0;

    function automatic logic [11:0] pat(input int idx);
        return (idx == 37) ? 12'hABC : 12'(idx * 7 + 3);
    endfunction

    // Advance one clock, then drive the memory side from the model's view of
    // outstanding words (never from DUT outputs).
    task automatic cyc();
        int pend;
        if (rd_req_valid && rd_req_ready && !rst) dut_hs++;
        @(posedge clk);
        #1;
        rd_req_ready = ($urandom_range(99) < rdy_pct);
        pend = m_reqs * BL - m_words;
        if (m_fetch && pend > 0 && $urandom_range(99) < val_pct) begin
            rd_data_valid = 1'b1;
            rd_data = pattern ? pat(m_words) : 12'($urandom);
        end else if (!m_fetch && $urandom_range(99) < stale_pct) begin
            rd_data_valid = 1'b1;
            rd_data = 12'hFFF;
        end else begin
            rd_data_valid = 1'b0;
            rd_data = 12'($urandom);
        end
    endtask

    task automatic trigger(input int y);
        pixel_y = 10'(y); pixel_x = 10'(H); active = 1'b0;
        cyc();
        pixel_x = 10'd0;
    endtask

    task automatic run_fetch(input string name, input int budget);
        int n = 0;
        while (m_fetch && n < budget) begin
            cyc();
            n++;
        end
        chk({name, " finished within budget"}, int'(n < budget), 1);
        chk({name, " busy low"}, busy, 0);
    endtask

    task automatic show(input int y, input int x);
        pixel_y = 10'(y); pixel_x = 10'(x); active = 1'b1;
        cyc();
        active = 1'b0; pixel_x = 10'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; pixel_x = 0; pixel_y = 0; hsync = 1; vsync = 1; active = 1;
        rd_req_ready = 0; rd_data_valid = 0; rd_data = 0;
        cyc();
        chk_en = 1;
        cyc();
        // Reset state, with active/syncs held high to show reset dominates.
        chk("reset rd_req_valid", rd_req_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset underflow_count", underflow_count, 0);
        chk("reset pixel_valid", pixel_valid, 0);
        chk("reset pixel_data", pixel_data, 0);
        chk("reset hsync_o", hsync_o, 0);
        rst = 0; active = 0; vsync = 0;
        cyc();
        chk("hsync delayed", hsync_o, 1);
        chk("vsync delayed", vsync_o, 0);
        hsync = 0;
        cyc();

        // Frame start fetch of line 0.
        rdy_pct = 100; val_pct = 100; pattern = 1;
        dut_hs = 0;
        trigger(VT - 1);
        chk("frame start valid", rd_req_valid, 1);
        chk("frame start addr", rd_req_addr, 0);
        chk("frame start busy", busy, 1);
        run_fetch("frame start", 3000);
        chk("frame start request count", dut_hs, 50);

        // Display from bank 0.
        show(0, 37);
        chk("display word37", pixel_data, 12'hABC);
        chk("display valid", pixel_valid, 1);
        cyc();
        chk("display inactive data", pixel_data, 0);
        chk("display inactive valid", pixel_valid, 0);
        for (int i = 0; i < 40; i++) begin
            pixel_y = 10'd0; pixel_x = 10'($urandom_range(H - 1));
            active = 1'($urandom_range(1));
            cyc();
        end
        active = 0;

        // Lines 1..5 under random backpressure; line 5 lands in bank 1 at 4000.
        rdy_pct = 60; val_pct = 70;
        for (int y = 0; y < 4; y++) begin
            trigger(y);
            run_fetch("line fetch", 6000);
        end
        trigger(4);
        chk("line5 first addr", rd_req_addr, 4000);
        run_fetch("line5 fetch", 6000);
        show(5, 123);
        chk("line5 bank1 word123", pixel_data, 12'h360);

        // Dead lines produce no fetch.
        for (int y = VA - 1; y <= VT - 2; y++) begin
            trigger(y);
            chk("no trigger busy", busy, 0);
        end

        // Backpressure and underflow.
        rst = 1; cyc(); rst = 0;
        rdy_pct = 100; val_pct = 0; dut_hs = 0;
        trigger(VT - 1);
        cyc(); cyc();
        rdy_pct = 0;
        cyc();
        chk("bp addr after 3", rd_req_addr, 48);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("bp valid held", rd_req_valid, 1);
            chk("bp addr held", rd_req_addr, 48);
        end
        pixel_y = 10'd10; pixel_x = 10'(H);
        cyc();
        pixel_x = 10'd0;
        chk("underflow pulse", underflow, 1);
        chk("underflow count 1", underflow_count, 1);
        cyc();
        chk("underflow single", underflow, 0);
        pixel_x = 10'(H);
        for (int i = 0; i < 300; i++) cyc();
        pixel_x = 10'd0;
        chk("underflow saturate", underflow_count, 255);
        rdy_pct = 100; val_pct = 100;
        run_fetch("bp fetch", 3000);
        chk("bp request count", dut_hs, 50);

        // Reset on the 10th returned word, then stale returns, then refetch.
        trigger(VT - 1);
        for (int n = 0; n < 200; n++) begin
            if (m_words == 9 && rd_data_valid) break;
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0;
        chk("abort busy", busy, 0);
        chk("abort valid", rd_req_valid, 0);
        stale_pct = 100;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("stale busy", busy, 0);
        end
        stale_pct = 0;
        trigger(VT - 1);
        chk("refetch addr", rd_req_addr, 0);
        run_fetch("refetch", 3000);
        show(0, 0);
        chk("refetch word0", pixel_data, 12'h003);
        show(0, 9);
        chk("refetch word9", pixel_data, 12'h042);
        show(0, H - 1);
        chk("refetch word799", pixel_data, 12'h5DC);

        // Randomized raster, memory timing, stale returns and resets.
        pattern = 0; rdy_pct = 70; val_pct = 80; stale_pct = 30;
        for (int i = 0; i < 15000; i++) begin
            rst = ($urandom_range(2999) == 0);
            pixel_y = 10'($urandom_range(VT - 1));
            if ($urandom_range(299) == 0) begin
                pixel_x = 10'(H); active = 0;
            end else begin
                pixel_x = 10'($urandom_range(H - 1));
                active = 1'($urandom_range(1));
            end
            hsync = 1'($urandom_range(1));
            vsync = 1'($urandom_range(1));
            cyc();
        end
        rst = 0; stale_pct = 0;
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
